// File: rtl/counter_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// counter_ctrl_pkg
// Shared types and helpers for the counter run controller.
//   state_e    : controller FSM states (IDLE, LOAD, COUNT, DONE)
//   CNT_W_DEF  : default counter width, matches the 8-bit counter datapath
//   run_len()  : number of enabled count cycles for a run, (term - start)
//                modulo 2^CNT_W_DEF; used by benches to predict latency
// ---------------------------------------------------------------------------
package counter_ctrl_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Wrap-around is intentional: subtraction is truncated to the counter width.
  function automatic logic [CNT_W_DEF-1:0] run_len(
    input logic [CNT_W_DEF-1:0] start_v,
    input logic [CNT_W_DEF-1:0] term_v
  );
    return term_v - start_v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: selects the first asserted request at or
// after the pointer, wrapping cyclically.
//   req_i      [NREQ]  : request vector
//   ptr_i      [IDX_W] : highest-priority index this cycle
//   pick_oh_o  [NREQ]  : one-hot winner (zero when no request)
//   pick_idx_o [IDX_W] : binary index of the winner
//   valid_o            : at least one request is asserted
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  pick_oh_o,
  output logic [IDX_W-1:0] pick_idx_o,
  output logic             valid_o
);

  // One extra bit so ptr + offset cannot overflow before the modulo fold.
  logic [IDX_W:0] cand;

  always_comb begin
    pick_oh_o  = '0;
    pick_idx_o = '0;
    valid_o    = 1'b0;
    cand       = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NREQ)) begin
        cand = cand - (IDX_W+1)'(NREQ);
      end
      // First hit in rotated order wins; later hits are ignored.
      if (!valid_o && req_i[cand[IDX_W-1:0]]) begin
        valid_o                       = 1'b1;
        pick_idx_o                    = cand[IDX_W-1:0];
        pick_oh_o[cand[IDX_W-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_run_ctrl.sv
// ---------------------------------------------------------------------------
// counter_run_ctrl
// Shares one loadable up-counter between NREQ requesters. Each granted run
// loads the owner's start value, counts up (modulo 2^CNT_W) until cnt_cout
// equals the owner's terminal value, then pulses done to the owner. Owners
// are chosen round-robin; a run can be aborted by dropping its request.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   req        [NREQ]   : per-requester run request (drop to abort)
//   start_val  [NREQ*W] : per-requester start value, slice i = requester i
//   term_val   [NREQ*W] : per-requester terminal value
//   hold                : pauses counting while in COUNT
//   gnt        [NREQ]   : one-hot grant to the current owner
//   done       [NREQ]   : one-cycle completion pulse to the owner
//   busy                : controller not idle
//   cnt_load            : counter load strobe
//   cnt_enable          : counter enable (load needs enable too)
//   cnt_data   [W]      : counter load data (latched start value)
//   cnt_cout   [W]      : counter output, compared against terminal value
// ---------------------------------------------------------------------------
module counter_run_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] start_val,
  input  logic [NREQ*CNT_W-1:0] term_val,
  input  logic                  hold,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  cnt_load,
  output logic                  cnt_enable,
  output logic [CNT_W-1:0]      cnt_data,
  input  logic [CNT_W-1:0]      cnt_cout
);

  localparam int IDX_W = $clog2(NREQ);

  // -------------------------------------------------------------------------
  // Per-requester views of the flattened value buses
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] start_arr [NREQ];
  logic [CNT_W-1:0] term_arr  [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign start_arr[gi] = start_val[gi*CNT_W +: CNT_W];
    assign term_arr[gi]  = term_val[gi*CNT_W +: CNT_W];
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e           state_q,    state_d;
  logic [IDX_W-1:0] owner_q,    owner_d;
  logic [NREQ-1:0]  owner_oh_q, owner_oh_d;
  logic [IDX_W-1:0] ptr_q,      ptr_d;
  logic [CNT_W-1:0] start_q,    start_d;
  logic [CNT_W-1:0] term_q,     term_d;

  logic [NREQ-1:0]  gnt_q;
  logic [NREQ-1:0]  done_q;
  logic             busy_q;
  logic             load_q;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic [NREQ-1:0]  pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i      (req),
    .ptr_i      (ptr_q),
    .pick_oh_o  (pick_oh),
    .pick_idx_o (pick_idx),
    .valid_o    (pick_valid)
  );

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] owner_inc;
  logic             owner_req;
  logic             term_hit;

  // Pointer moves just past the finishing (or aborting) owner.
  assign owner_inc = (owner_q == IDX_W'(NREQ-1)) ? '0 : owner_q + 1'b1;
  assign owner_req = |(req & owner_oh_q);
  assign term_hit  = (cnt_cout == term_q);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    owner_oh_d = owner_oh_q;
    ptr_d      = ptr_q;
    start_d    = start_q;
    term_d     = term_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = LOAD;
          owner_d    = pick_idx;
          owner_oh_d = pick_oh;
          start_d    = start_arr[pick_idx];
          term_d     = term_arr[pick_idx];
        end
      end

      LOAD: begin
        if (!owner_req) begin
          state_d = IDLE;
          ptr_d   = owner_inc;
        end else begin
          state_d = COUNT;
        end
      end

      COUNT: begin
        // Abort wins over completion: a dropped request never sees done.
        if (!owner_req) begin
          state_d = IDLE;
          ptr_d   = owner_inc;
        end else if (term_hit) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // Request level is ignored here; the pulse always completes.
        state_d = IDLE;
        ptr_d   = owner_inc;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM registers and registered outputs. The outputs are computed from the
  // next state so they line up with the state they describe.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      owner_oh_q <= '0;
      ptr_q      <= '0;
      start_q    <= '0;
      term_q     <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_oh_q <= owner_oh_d;
      ptr_q      <= ptr_d;
      start_q    <= start_d;
      term_q     <= term_d;
      gnt_q      <= (state_d != IDLE) ? owner_oh_d : '0;
      done_q     <= (state_d == DONE) ? owner_oh_d : '0;
      busy_q     <= (state_d != IDLE);
      load_q     <= (state_d == LOAD);
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign gnt      = gnt_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign cnt_load = load_q;
  assign cnt_data = start_q;

  // Enable must react to cnt_cout in the same cycle, otherwise the counter
  // would step one past the terminal value. The terminal compare outranks
  // hold, and the counter only loads when enable accompanies load.
  assign cnt_enable = load_q |
                      ((state_q == COUNT) && !term_hit && !hold);

endmodule

// File: tb/tb_counter_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_run_ctrl
// Drives runs into counter_run_ctrl with a behavioural loadable counter in
// the loop. Each run pushes its expected completion (owner, cycle, final
// count) into a scoreboard; the done monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_counter_run_ctrl;
  import counter_ctrl_pkg::*;

  localparam int NREQ  = 4;
  localparam int CNT_W = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] start_val;
  logic [NREQ*CNT_W-1:0] term_val;
  logic                  hold;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic                  cnt_load;
  logic                  cnt_enable;
  logic [CNT_W-1:0]      cnt_data;
  logic [CNT_W-1:0]      cnt_cout;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int         idx;
    int         cyc;
    logic [7:0] cout;
  } exp_t;

  exp_t sb[$];

  counter_run_ctrl #(
    .NREQ  (NREQ),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .start_val  (start_val),
    .term_val   (term_val),
    .hold       (hold),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .cnt_load   (cnt_load),
    .cnt_enable (cnt_enable),
    .cnt_data   (cnt_data),
    .cnt_cout   (cnt_cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 8-bit counter: load needs enable; shares the reset.
  always @(posedge clk or posedge reset) begin
    if (reset)                       cnt_cout <= '0;
    else if (cnt_load && cnt_enable) cnt_cout <= cnt_data;
    else if (cnt_enable)             cnt_cout <= cnt_cout + 8'd1;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Done monitor / scoreboard consumer, plus grant exclusivity.
  always @(negedge clk) begin
    if (!reset) begin
      check("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
      if (done != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          exp_t e;
          logic [NREQ-1:0] exp_oh;
          e      = sb.pop_front();
          exp_oh = 4'b0001 << e.idx;
          check("done_owner", done, exp_oh);
          check("done_cycle", cyc, e.cyc);
          check("done_cout",  cnt_cout, e.cout);
          $display("run: owner=%0d done=%b cycle=%0d cout=0x%02h",
                   e.idx, done, cyc, cnt_cout);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"},    gnt,        0);
    check({tag, "_done"},   done,       0);
    check({tag, "_busy"},   busy,       0);
    check({tag, "_load"},   cnt_load,   0);
    check({tag, "_enable"}, cnt_enable, 0);
    check({tag, "_data"},   cnt_data,   0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req   = '0;
    hold  = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One run for requester idx. Optional hold of hold_len cycles when cout
  // first reaches hold_at; extra requesters are raised alongside in cycle 0
  // and dropped once the grant is seen.
  task automatic run_one(input int idx, input logic [7:0] s,
                         input logic [7:0] t, input int hold_len,
                         input logic [7:0] hold_at,
                         input logic [NREQ-1:0] extra);
    int c0, n, k, hcnt;
    bit held;
    exp_t e;
    logic [7:0] ev;
    logic [NREQ-1:0] exp_oh;
    k = int'(run_len(s, t));
    exp_oh = 4'b0001 << idx;
    @(negedge clk); #1;
    start_val[idx*8 +: 8] = s;
    term_val[idx*8 +: 8]  = t;
    req      = req | extra;
    req[idx] = 1'b1;
    c0       = cyc;
    e.idx = idx; e.cyc = c0 + k + 3 + hold_len; e.cout = t;
    sb.push_back(e);

    @(negedge clk); #1;
    check("c1_gnt",    gnt,        exp_oh);
    check("c1_load",   cnt_load,   1);
    check("c1_enable", cnt_enable, 1);
    check("c1_data",   cnt_data,   s);
    req      = req & ~extra;
    req[idx] = 1'b1;

    held = 0;
    hcnt = 0;
    for (int it = 0; it < 600 && sb.size() > 0; it++) begin
      @(negedge clk); #1;
      n = cyc - c0;
      if (hold_len == 0) begin
        ev = s + 8'(n - 2);
        if (n >= 2 && n <= k + 2) check("cout_seq", cnt_cout, ev);
        if (n >= 2 && n <= k + 1) check("enable_on", cnt_enable, 1);
        if (n == k + 2)           check("enable_off", cnt_enable, 0);
      end else begin
        if (hold) begin
          check("hold_cout", cnt_cout, hold_at);
          hcnt++;
          if (hcnt == hold_len) hold = 1'b0;
        end else if (!held && n >= 2 && cnt_cout == hold_at) begin
          hold = 1'b1;
          held = 1;
          #1 check("hold_enable", cnt_enable, 0);
        end
      end
    end
    check("timeout_pending", sb.size(), 0);
    sb.delete();
    req[idx] = 1'b0;
    hold     = 1'b0;
    check("final_cout", cnt_cout, t);

    @(negedge clk); #1;
    check("after_gnt",  gnt,      0);
    check("after_busy", busy,     0);
    check("after_cout", cnt_cout, t);
  endtask

  initial begin
    int c0, n;
    bit found;
    exp_t e;

    reset     = 1'b1;
    req       = '0;
    hold      = 1'b0;
    start_val = '0;
    term_val  = '0;

    apply_reset();

    // Basic run, wrap-around run, zero-length run.
    run_one(0, 8'h10, 8'h14, 0, 8'h00, 4'b0000);
    run_one(1, 8'hFE, 8'h01, 0, 8'h00, 4'b0000);
    run_one(2, 8'h33, 8'h33, 0, 8'h00, 4'b0000);

    // Two requesters from reset: 0, then 2, then 0 again.
    apply_reset();
    @(negedge clk); #1;
    start_val[0*8 +: 8] = 8'h20; term_val[0*8 +: 8] = 8'h22;
    start_val[2*8 +: 8] = 8'h40; term_val[2*8 +: 8] = 8'h41;
    req = 4'b0101;
    c0  = cyc;
    e.idx = 0; e.cyc = c0 + 5;  e.cout = 8'h22; sb.push_back(e);
    e.idx = 2; e.cyc = c0 + 10; e.cout = 8'h41; sb.push_back(e);
    e.idx = 0; e.cyc = c0 + 16; e.cout = 8'h22; sb.push_back(e);
    for (int it = 0; it < 200 && sb.size() > 0; it++) begin
      @(negedge clk); #1;
      n = cyc - c0;
      if (n == 1)  check("rr_gnt_first",  gnt, 4'b0001);
      if (n == 7)  check("rr_gnt_second", gnt, 4'b0100);
      if (n == 12) check("rr_gnt_third",  gnt, 4'b0001);
    end
    check("rr_timeout_pending", sb.size(), 0);
    sb.delete();
    req = '0;
    @(negedge clk); #1;
    check("rr_after_busy", busy, 0);

    // Hold for two cycles at cout=0x02: done slips to cycle 10.
    run_one(0, 8'h00, 8'h05, 2, 8'h02, 4'b0000);

    // Abort requester 3 at cout=0x42.
    @(negedge clk); #1;
    start_val[3*8 +: 8] = 8'h40; term_val[3*8 +: 8] = 8'h50;
    req[3] = 1'b1;
    found  = 0;
    for (int it = 0; it < 200 && !found; it++) begin
      @(negedge clk); #1;
      if (gnt[3] && !cnt_load && cnt_cout == 8'h42) found = 1;
    end
    check("abort_reached", found, 1);
    req[3] = 1'b0;
    @(negedge clk); #1;
    check("abort_gnt",  gnt,  0);
    check("abort_busy", busy, 0);

    // Pointer moved past 3: with 0 and 3 both requesting, 0 wins.
    run_one(0, 8'h60, 8'h61, 0, 8'h00, 4'b1000);

    // Asynchronous reset in the middle of COUNT.
    @(negedge clk); #1;
    start_val[1*8 +: 8] = 8'h00; term_val[1*8 +: 8] = 8'h80;
    req[1] = 1'b1;
    found  = 0;
    for (int it = 0; it < 200 && !found; it++) begin
      @(negedge clk); #1;
      if (gnt[1] && !cnt_load && cnt_cout == 8'h10) found = 1;
    end
    check("midrun_reached", found, 1);
    #2 reset = 1'b1;
    #1;
    check_idle_outputs("midrun_reset");
    req = '0;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    check("post_reset_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_run_ctrl.md
Name: counter_run_ctrl

Overview:
Sequencer and arbiter that shares one 8-bit loadable counter (load/enable/data in, cout out) between NREQ requesters. Each requester asks for a "run": load a start value, count up to a terminal value (8-bit wrap allowed), then receive a done pulse. Requests are granted round-robin, one run at a time. The block sits directly in front of the counter's load, enable and data inputs and observes cout.

Parameters:
NREQ, 4, number of requesters (2..8)
CNT_W, 8, counter width; must match the counter datapath

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
req  in  NREQ  per-requester run request; held high until done, or dropped to abort
start_val  in  NREQ*CNT_W  per-requester start value (slice i belongs to requester i)
term_val  in  NREQ*CNT_W  per-requester terminal value
hold  in  1  global pause; freezes counting while in COUNT
gnt  out  NREQ  one-hot grant to the current run owner
done  out  NREQ  one-cycle completion pulse to the owner
busy  out  1  high when the FSM is not IDLE
cnt_load  out  1  drives counter load
cnt_enable  out  1  drives counter enable
cnt_data  out  CNT_W  drives counter data
cnt_cout  in  CNT_W  counter output

Behaviour:
- Reset (async, active-high): state IDLE; gnt, done, busy, cnt_load, cnt_enable all 0; cnt_data 0; rr pointer 0; latched start/term 0.
- FSM states: IDLE, LOAD, COUNT, DONE. State and latched values are registered. Outputs are decoded from state, except cnt_enable in COUNT, which also depends on the cnt_cout compare and hold.
- IDLE: if any req is high, pick the first requester at or after the rr pointer, cyclically. At the next edge: owner <= pick; gnt[pick] <= 1; latch start_val/term_val of the owner; state goes to LOAD. With no req, stay in IDLE.
- LOAD (exactly 1 cycle): cnt_load=1, cnt_enable=1, cnt_data=latched start. The counter must have both load and enable high to load. Next state is COUNT.
- COUNT:
  - If cnt_cout == latched term: cnt_enable=0; next state is DONE. This has priority over hold.
  - Else if hold=1: cnt_enable=0; stay in COUNT.
  - Else: cnt_enable=1, cnt_load=0; stay in COUNT.
- DONE (exactly 1 cycle): done[owner]=1 and gnt[owner] remains 1. Next edge: gnt cleared, rr pointer <= owner+1 mod NREQ, state goes to IDLE.
- Abort: if req[owner] is low during LOAD or COUNT, the next edge goes to IDLE with gnt cleared, no done pulse, and the pointer advances past the owner. req low during DONE is ignored.
- Latency, with no hold, req sampled in IDLE at cycle 0, and k = (term - start) mod 2^CNT_W:
  - gnt is high in cycles 1..k+3.
  - cnt_load is high in cycle 1.
  - cnt_enable is high in cycles 1..k+1.
  - done is high in cycle k+3.
  - Each hold cycle in COUNT adds 1 cycle.
- Wrap-around: counting proceeds modulo 2^CNT_W, e.g. 0xFE -> 0xFF -> 0x00.
- term == start: k=0; COUNT lasts 1 cycle with enable=0.
- Requests arriving while busy wait; there is no preemption.
- cnt_data holds the latched start value outside LOAD (don't-care to the counter).
- Minimum spacing between runs: one IDLE cycle.
- busy = (state != IDLE).
- Reset mid-run: immediate return to the reset values; the counter is reset by the same reset.

Decomposition:
- Package counter_ctrl_pkg: state enum (IDLE, LOAD, COUNT, DONE), CNT_W default constant, run-length helper function (term - start mod 2^CNT_W) for bench use.
- Sub-module rr_arbiter: combinational round-robin pick from req and pointer; outputs one-hot pick and a valid flag.

Test Plan:
- req[0], start=0x10, term=0x14, hold=0 -> gnt[0] in cycle 1; load with data 0x10 in cycle 1; cout goes 0x10..0x14; done[0] in cycle 7; cout stays 0x14 after.
- req[1], start=0xFE, term=0x01 -> cout sequence FE, FF, 00, 01; done[1] in cycle 6.
- req[2], start=term=0x33 -> enable is never asserted without load; done[2] in cycle 3.
- req[0] and req[2] raised together from reset, both held -> run for 0 first, then 2, then 0 again if still requesting (pointer now 1); gnt is never multi-hot.
- Run start=0x00, term=0x05 with hold=1 for 2 cycles while cout=0x02 -> cout holds 0x02 for those cycles; done delayed by exactly 2 cycles (cycle 10).
- Drop req[3] while cout=0x42 mid-COUNT -> no done; gnt low the next cycle; next grant goes to requester 0. Assert reset mid-COUNT on another run -> all outputs 0 immediately.
